r_ram_to_uart: RTL and testbench
================================

Name: r_ram_to_uart

Overview:
- Downstream readback stage for the UART-loaded block RAM.
- On a start request, reads DEPTH bytes sequentially from RAM (address 0 upward) and serialises each byte on a UART TX line (8N1, LSB first).
- Pulses into a sticky end flag when the last byte's stop bit completes.
- Shares the same RAM via its read port. Used to dump loaded data or results back to the host.

Parameters:
- CLK_FREQ, 50000000, sys_clk frequency in Hz.
- BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer division), 434 at defaults.
- DEPTH, 15'h22a0, number of bytes transferred per run (1..32767).
- RAM_LATENCY, 2, cycles from address/ena valid to ram_dout valid (1..3).

Ports:
- sys_clk  input  1  clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- r_ram_to_uart_start  input  1  level request; run proceeds while high.
- ram_dout  input  8  RAM read data.
- address  output  15  RAM read address; always equals the internal byte counter.
- ena  output  1  RAM read enable.
- uart_txd  output  1  serial output, idle high.
- busy  output  1  high from leaving IDLE until returning to IDLE or DONE.
- r_ram_to_uart_end  output  1  run complete; sticky until start goes low.

Behaviour:
- Reset values: address/counter=0, ena=0, uart_txd=1, busy=0, r_ram_to_uart_end=0, state=IDLE. Reset mid-run aborts immediately; txd returns high asynchronously.
- end clears on any cycle with start=0, in any state.
- FSM states are IDLE, RD, WAIT, LOAD, TX, NEXT, DONE.
- IDLE: if start=1 and end=0, go to RD. Otherwise hold; txd=1, ena=0.
- RD: ena=1 for one cycle, address=counter. Then go to WAIT.
- WAIT: hold RAM_LATENCY-1 cycles (zero cycles when RAM_LATENCY=1). Then go to LOAD.
- LOAD: capture ram_dout into a 10-bit shift frame {1, data[7:0], 0}. Clear the bit counter and baud counter. Go to TX.
- TX:
  - txd=frame[0]; each bit is held exactly BAUD_DIV cycles, then the frame shifts right.
  - After 10 bits (start bit, D0..D7, stop bit), go to NEXT.
  - Start-bit falling edge occurs RAM_LATENCY+2 cycles after the IDLE cycle that sampled start.
- NEXT: counter increments.
  - If counter was DEPTH-1: go to DONE.
  - Else if start=1: go to RD.
  - Else: go to IDLE, keeping counter, so reassertion resumes at the next address.
- DONE: counter=0, end=1, busy=0, go to IDLE. end then blocks relaunch until start drops.
- A byte is never truncated: start low mid-byte finishes that byte, then idles.
- Inter-byte gap (txd high between a stop bit and the next start bit) = RAM_LATENCY+2 cycles.
- Counter width is 15 bits; it never wraps because DONE clears it at DEPTH-1.
- ena is high only in RD; address is stable from RD through LOAD.
- start high and low in the same cycle as DONE: end still sets, then clears on the next cycle where start=0.

Test Plan:
- Setup: CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), DEPTH=4, RAM_LATENCY=2; RAM model holds A5,3C,00,FF at addresses 0..3.
- Single run:
  - Stimulus: raise start and hold.
  - txd first falls 4 cycles after start is sampled. Bits decode to A5,3C,00,FF, each bit 10 cycles, stop bits high.
  - Addresses read are 0,1,2,3 with one ena pulse each. end=1 after the last stop bit; counter=0.
- Sticky end: keep start high after end=1.
  - No further ena pulses and txd stays 1. Drop start: end=0 next cycle. Raise start again: a new run begins at address 0.
- Pause/resume: drop start during bit D3 of byte 1.
  - Byte 1 (3C) completes intact, then the block idles with address=2.
  - Re-raise start: bytes 00,FF are sent, then end=1.
- Reset mid-run: assert sys_rst_n=0 during byte 2's data bits.
  - txd=1, busy=0, address=0, ena=0 immediately. After release plus start, the run restarts from A5.
- Gap and timing: measure the idle-high gap between consecutive frames.
  - Gap is exactly 4 cycles.
  - Sweep RAM_LATENCY=1 and 3: captured data is still correct, and the gap is 3 and 5 cycles respectively.

Source files
------------

// File: rtl/r_ram_to_uart_if.sv
// rtl/r_ram_to_uart_if.sv - RAM read port shared between the readback stage and the block RAM
interface r_ram_to_uart_if;
  logic [14:0] address;
  logic        ena;
  logic [7:0]  ram_dout;

  modport master (
    output address,
    output ena,
    input  ram_dout
  );

  modport slave (
    input  address,
    input  ena,
    output ram_dout
  );
endinterface

// File: rtl/r_ram_to_uart.sv
// rtl/r_ram_to_uart.sv - sequential RAM readback serialised as 8N1 UART frames
module r_ram_to_uart #(
  parameter int          CLK_FREQ    = 50000000,
  parameter int          BAUD        = 115200,
  parameter logic [14:0] DEPTH       = 15'h22a0,
  parameter int          RAM_LATENCY = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              r_ram_to_uart_start,
  r_ram_to_uart_if.master   ram,
  output logic              uart_txd,
  output logic              busy,
  output logic              r_ram_to_uart_end
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  // WAIT covers the RAM latency beyond the single RD cycle
  localparam int WAIT_CYC = RAM_LATENCY - 1;
  localparam logic [1:0] WAIT_LAST = 2'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_LOAD,
    S_TX,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [14:0]       cnt_q, cnt_d;
  logic [9:0]        frame_q, frame_d;
  logic [3:0]        bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [1:0]        wait_q, wait_d;
  logic              end_q, end_d;

  // Outputs decode straight from registered state so reset forces them idle at once
  assign ram.address       = cnt_q;
  assign ram.ena           = (state_q == S_RD);
  assign uart_txd          = (state_q == S_TX) ? frame_q[0] : 1'b1;
  assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign r_ram_to_uart_end = end_q;

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      wait_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      wait_q  <= wait_d;
      end_q   <= end_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    wait_d  = wait_q;
    // end is sticky while start stays high, cleared by any low-start cycle
    end_d   = r_ram_to_uart_start ? end_q : 1'b0;

    case (state_q)
      S_IDLE: begin
        if (r_ram_to_uart_start && !end_q) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        wait_d  = '0;
        state_d = (WAIT_CYC == 0) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_LOAD: begin
        frame_d = {1'b1, ram.ram_dout, 1'b0};
        bit_d   = '0;
        baud_d  = '0;
        state_d = S_TX;
      end
      S_TX: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          frame_d = {1'b1, frame_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = S_NEXT;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_NEXT: begin
        cnt_d = cnt_q + 15'd1;
        if (cnt_q == DEPTH - 15'd1) begin
          state_d = S_DONE;
        end else if (r_ram_to_uart_start) begin
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        end_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_r_ram_to_uart.sv
// tb/tb_r_ram_to_uart.sv - bench for r_ram_to_uart across RAM latencies 1..3
module tb_r_ram_to_uart;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst_n;
  logic start;
  int   sel;
  logic start1, start2, start3;
  logic txd1, txd2, txd3;
  logic busy1, busy2, busy3;
  logic end1, end2, end3;
  logic        txd_s, busy_s, end_s, ena_s;
  logic [14:0] addr_s;

  r_ram_to_uart_if if1 ();
  r_ram_to_uart_if if2 ();
  r_ram_to_uart_if if3 ();

  logic [7:0] mem [4];
  logic [7:0] p1 [1];
  logic [7:0] p2 [2];
  logic [7:0] p3 [3];

  always @(posedge sys_clk) begin
    p1[0] <= if1.ena ? mem[if1.address[1:0]] : 8'hxx;
    p2[0] <= if2.ena ? mem[if2.address[1:0]] : 8'hxx;
    p2[1] <= p2[0];
    p3[0] <= if3.ena ? mem[if3.address[1:0]] : 8'hxx;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if1.ram_dout = p1[0];
  assign if2.ram_dout = p2[1];
  assign if3.ram_dout = p3[2];

  r_ram_to_uart #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(15'd4), .RAM_LATENCY(1)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .r_ram_to_uart_start(start1),
    .ram(if1), .uart_txd(txd1), .busy(busy1), .r_ram_to_uart_end(end1));
  r_ram_to_uart #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(15'd4), .RAM_LATENCY(2)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .r_ram_to_uart_start(start2),
    .ram(if2), .uart_txd(txd2), .busy(busy2), .r_ram_to_uart_end(end2));
  r_ram_to_uart #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(15'd4), .RAM_LATENCY(3)) u3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .r_ram_to_uart_start(start3),
    .ram(if3), .uart_txd(txd3), .busy(busy3), .r_ram_to_uart_end(end3));

  always_comb begin
    start1 = start && (sel == 1);
    start2 = start && (sel == 2);
    start3 = start && (sel == 3);
    case (sel)
      1: begin txd_s = txd1; busy_s = busy1; end_s = end1; ena_s = if1.ena; addr_s = if1.address; end
      3: begin txd_s = txd3; busy_s = busy3; end_s = end3; ena_s = if3.ena; addr_s = if3.address; end
      default: begin txd_s = txd2; busy_s = busy2; end_s = end2; ena_s = if2.ena; addr_s = if2.address; end
    endcase
  end

  logic [14:0] enaq [$];
  always @(negedge sys_clk) begin
    if (ena_s === 1'b1) enaq.push_back(addr_s);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic recv_byte(input int drop_at, output logic [7:0] data, output int hi, output logic ok);
    logic [9:0] fr;
    hi = 0;
    ok = 1'b1;
    fr = '0;
    @(negedge sys_clk);
    while (txd_s !== 1'b0 && hi < 300) begin
      hi++;
      @(negedge sys_clk);
    end
    chk("start_bit_seen", {31'd0, txd_s}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge sys_clk);
      if (i == drop_at) start = 1'b0;
      if (i % 10 == 0) fr[i/10] = txd_s;
      else if (txd_s !== fr[i/10]) ok = 1'b0;
    end
    data = fr[8:1];
    if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 1'b0;
  endtask

  task automatic send_check(input int a, input int drop_at, input bit first);
    logic [7:0] d;
    int hi;
    logic ok;
    recv_byte(drop_at, d, hi, ok);
    chk($sformatf("data_l%0d_a%0d", sel, a), {24'd0, d}, {24'd0, mem[a]});
    chk("frame_ok", {31'd0, ok}, 32'd1);
    if (first) chk($sformatf("latency_l%0d", sel), hi + 1, sel + 2);
    else chk($sformatf("gap_l%0d", sel), hi, sel + 2);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (end_s !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("end_set", {31'd0, end_s}, 32'd1);
    chk("addr_after_done", {17'd0, addr_s}, 32'd0);
    chk("busy_after_done", {31'd0, busy_s}, 32'd0);
  endtask

  task automatic check_enaq(input int from, input int n);
    chk("ena_pulses", enaq.size(), n);
    for (int i = 0; i < enaq.size() && i < n; i++)
      chk($sformatf("ena_addr%0d", i), {17'd0, enaq[i]}, from + i);
    enaq.delete();
  endtask

  task automatic full_run();
    start = 1'b1;
    for (int a = 0; a < 4; a++) send_check(a, -1, a == 0);
    wait_end();
    check_enaq(0, 4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stay;
    int n;
    sel = 2;
    start = 1'b0;
    sys_rst_n = 1'b0;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
    repeat (3) @(negedge sys_clk);
    chk("rst_txd", {31'd0, txd_s}, 32'd1);
    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    chk("rst_addr", {17'd0, addr_s}, 32'd0);
    chk("rst_ena", {31'd0, ena_s}, 32'd0);
    chk("rst_end", {31'd0, end_s}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    enaq.delete();

    // single run with start held
    full_run();

    // end is sticky while start stays high
    stay = 1'b1;
    repeat (50) begin
      @(negedge sys_clk);
      if (txd_s !== 1'b1) stay = 1'b0;
    end
    chk("sticky_txd_high", {31'd0, stay}, 32'd1);
    chk("sticky_no_ena", enaq.size(), 0);
    chk("end_held", {31'd0, end_s}, 32'd1);
    start = 1'b0;
    @(negedge sys_clk);
    chk("end_cleared", {31'd0, end_s}, 32'd0);

    // relaunch from address 0
    full_run();
    start = 1'b0;
    @(negedge sys_clk);

    // pause during D3 of byte 1, then resume
    start = 1'b1;
    send_check(0, -1, 1'b1);
    send_check(1, 45, 1'b0);
    stay = 1'b1;
    repeat (30) begin
      @(negedge sys_clk);
      if (txd_s !== 1'b1) stay = 1'b0;
    end
    chk("pause_txd_high", {31'd0, stay}, 32'd1);
    chk("pause_busy", {31'd0, busy_s}, 32'd0);
    chk("pause_addr", {17'd0, addr_s}, 32'd2);
    chk("pause_end", {31'd0, end_s}, 32'd0);
    check_enaq(0, 2);
    start = 1'b1;
    send_check(2, -1, 1'b1);
    send_check(3, -1, 1'b0);
    wait_end();
    check_enaq(2, 2);
    start = 1'b0;
    @(negedge sys_clk);

    // reset in the middle of byte 2's data bits
    start = 1'b1;
    send_check(0, -1, 1'b1);
    send_check(1, -1, 1'b0);
    n = 0;
    @(negedge sys_clk);
    while (txd_s !== 1'b0 && n < 300) begin
      n++;
      @(negedge sys_clk);
    end
    chk("byte2_started", {31'd0, txd_s}, 32'd0);
    repeat (30) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_txd", {31'd0, txd_s}, 32'd1);
    chk("abort_busy", {31'd0, busy_s}, 32'd0);
    chk("abort_addr", {17'd0, addr_s}, 32'd0);
    chk("abort_ena", {31'd0, ena_s}, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    enaq.delete();
    full_run();
    start = 1'b0;
    @(negedge sys_clk);

    // randomized contents across all RAM latencies
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      for (int k = 0; k < 4; k++) mem[k] = 8'($urandom);
      @(negedge sys_clk);
      enaq.delete();
      full_run();
      start = 1'b0;
      @(negedge sys_clk);
      chk($sformatf("end_clear_l%0d", s), {31'd0, end_s}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
